// File: rtl/mem_common.sv
// -----------------------------------------------------------------------------
// mem_common
// Shared types for the front-end / fill-buffer interface: request and response
// packets, tracking-table entry, prefetch FSM encoding and line geometry.
// Contents:
//   ID_W, FB_ENTRIES     FB request ID width and tracking-table depth
//   LINE_BYTES, LINE_OFF cache line size and byte-offset width
//   t_fb_id, t_paddr     ID and physical address types
//   t_line               line number (address / LINE_BYTES)
//   t_fb_trk_entry       {valid, is_pf, orig_id}
//   t_pf_fsm             {PF_IDLE, PF_ISSUE, PF_WAIT, PF_FLUSH}
//   addr_line()          address -> line number
// -----------------------------------------------------------------------------
package mem_common;

    localparam int ID_W       = 2;
    localparam int FB_ENTRIES = 2 ** ID_W;
    localparam int LINE_BYTES = 64;
    localparam int LINE_OFF   = $clog2(LINE_BYTES);
    localparam int PADDR_W    = 32;
    localparam int LINE_W     = PADDR_W - LINE_OFF;
    localparam int DATA_W     = 32;

    typedef logic [ID_W-1:0]    t_fb_id;
    typedef logic [PADDR_W-1:0] t_paddr;
    typedef logic [LINE_W-1:0]  t_line;

    typedef struct packed {
        logic   valid;
        logic   is_pf;
        t_fb_id orig_id;
    } t_fb_trk_entry;

    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_ISSUE = 2'd1,
        PF_WAIT  = 2'd2,
        PF_FLUSH = 2'd3
    } t_pf_fsm;

    typedef struct packed {
        logic valid;
    } t_nuke_pkt;

    typedef struct packed {
        logic valid;
    } t_br_mispred_pkt;

    typedef struct packed {
        logic   valid;
        t_fb_id id;
        t_paddr addr;
    } t_fe_fb_req;

    typedef struct packed {
        logic              valid;
        t_fb_id            id;
        logic [DATA_W-1:0] data;
    } t_fb_fe_rsp;

    function automatic t_line addr_line(input t_paddr addr);
        return addr[PADDR_W-1:LINE_OFF];
    endfunction

endpackage

// File: rtl/fb_id_alloc.sv
// -----------------------------------------------------------------------------
// fb_id_alloc
// Combinational free-slot finder for a fill-buffer tracking table.
// Ports:
//   valid_vec  in   N   per-entry valid bits (registered table state)
//   free_idx   out  IW  lowest-index invalid entry (0 when none free)
//   any_free   out  1   at least one entry free
//   two_free   out  1   at least two entries free
// -----------------------------------------------------------------------------
module fb_id_alloc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid_vec,
    output logic [IW-1:0] free_idx,
    output logic          any_free,
    output logic          two_free
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] free_cnt;

    // Find-first-free (scanning high to low so the lowest index wins) plus popcount
    always_comb begin
        free_idx = '0;
        free_cnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            free_idx = valid_vec[i] ? free_idx : IW'(i);
            free_cnt = free_cnt + (valid_vec[i] ? CW'(0) : CW'(1));
        end
        any_free = (free_cnt != CW'(0));
        two_free = (free_cnt >= CW'(2));
    end

endmodule

// File: rtl/fe_fb_arb_chk.sv
// -----------------------------------------------------------------------------
// fe_fb_arb_chk
// Run-time checks for fe_fb_arb.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   rsp_valid    FB response valid
//   rsp_hit      tracking entry addressed by the response is valid
//   dmd_valid    demand request presented this cycle
//   any_free     allocator has at least one free entry
//   two_free     allocator has at least two free entries
//   flush        nuke or mispredict this cycle
// -----------------------------------------------------------------------------
module fe_fb_arb_chk (
    input logic clk,
    input logic reset,
    input logic rsp_valid,
    input logic rsp_hit,
    input logic dmd_valid,
    input logic any_free,
    input logic two_free,
    input logic flush
);

    // Protocol and occupancy invariants, ignored while in reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(rsp_valid && !rsp_hit));
            assert (!(dmd_valid && !any_free));
            assert (!(two_free && !any_free));
            assert (!$isunknown(flush));
        end
    end

endmodule

// File: rtl/fe_fb_arb.sv
// -----------------------------------------------------------------------------
// fe_fb_arb
// Owns the single fill-buffer request port and shares it between demand
// fetches from fe_ctl and a next-line instruction prefetcher. Each request is
// given a tracking-table ID; FB responses are routed to fe_ctl (demand) or
// absorbed (prefetch). Nukes and branch mispredicts cancel unissued prefetch.
// Build option: define FE_FB_ARB_PF_EN to include the prefetcher; without it
// the block is a demand pass-through with ID remapping and pf_busy = 0.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   nuke_rb1         retire nuke (.valid flushes)
//   br_mispred_ex0   branch redirect (.valid flushes)
//   fe_req_nnn       demand request from fe_ctl (no backpressure)
//   fe_rsp_nnn       demand response to fe_ctl
//   fb_req_nnn       request to the FB (always accepted)
//   fb_rsp_nnn       FB response, .id = tracking-table index
//   pf_busy          prefetcher active or prefetch outstanding
// -----------------------------------------------------------------------------
module fe_fb_arb
    import mem_common::*;
#(
    parameter int PF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  t_nuke_pkt       nuke_rb1,
    input  t_br_mispred_pkt br_mispred_ex0,
    input  t_fe_fb_req      fe_req_nnn,
    output t_fb_fe_rsp      fe_rsp_nnn,
    output t_fe_fb_req      fb_req_nnn,
    input  t_fb_fe_rsp      fb_rsp_nnn,
    output logic            pf_busy
);

    localparam int NE = FB_ENTRIES;

    t_fb_trk_entry [NE-1:0] trk_q;
    t_fb_trk_entry [NE-1:0] trk_d;
    logic [NE-1:0]          valid_vec_s;
    t_fb_id                 free_idx_s;
    logic                   any_free_s;
    logic                   two_free_s;
    logic                   flush_s;
    t_fb_trk_entry          hit_s;
    logic                   pf_issue_s;
    t_paddr                 pf_addr_s;

    assign flush_s = nuke_rb1.valid | br_mispred_ex0.valid;
    assign hit_s   = trk_q[fb_rsp_nnn.id];

    // Gather registered occupancy for the allocator
    always_comb begin
        valid_vec_s = '0;
        for (int i = 0; i < NE; i++) begin
            valid_vec_s[i] = trk_q[i].valid;
        end
    end

    fb_id_alloc #(
        .N  (NE),
        .IW (ID_W)
    ) u_alloc (
        .valid_vec (valid_vec_s),
        .free_idx  (free_idx_s),
        .any_free  (any_free_s),
        .two_free  (two_free_s)
    );

    // Response routing, request muxing and table next-state; outputs forced
    // to zero while reset is held
    always_comb begin
        trk_d      = trk_q;
        fb_req_nnn = '0;
        fe_rsp_nnn = '0;
        if (reset) begin
            trk_d = '0;
        end else begin
            // Responses to entries dropped by a reset miss the table and vanish
            if (fb_rsp_nnn.valid && hit_s.valid) begin
                if (!hit_s.is_pf) begin
                    fe_rsp_nnn    = fb_rsp_nnn;
                    fe_rsp_nnn.id = hit_s.orig_id;
                end else begin
                    fe_rsp_nnn = '0;
                end
                trk_d[fb_rsp_nnn.id] = '0;
            end else begin
                fe_rsp_nnn = '0;
            end

            // Allocation uses registered occupancy, so it never collides with
            // the entry a same-cycle response is freeing
            if (fe_req_nnn.valid) begin
                fb_req_nnn                 = fe_req_nnn;
                fb_req_nnn.id              = free_idx_s;
                trk_d[free_idx_s].valid    = 1'b1;
                trk_d[free_idx_s].is_pf    = 1'b0;
                trk_d[free_idx_s].orig_id  = fe_req_nnn.id;
            end else if (pf_issue_s) begin
                fb_req_nnn.valid           = 1'b1;
                fb_req_nnn.id              = free_idx_s;
                fb_req_nnn.addr            = pf_addr_s;
                trk_d[free_idx_s].valid    = 1'b1;
                trk_d[free_idx_s].is_pf    = 1'b1;
                trk_d[free_idx_s].orig_id  = '0;
            end else begin
                fb_req_nnn = '0;
            end
        end
    end

    // Tracking table state
    always_ff @(posedge clk) begin
        if (reset) begin
            trk_q <= '0;
        end else begin
            trk_q <= trk_d;
        end
    end

`ifdef FE_FB_ARB_PF_EN
    t_pf_fsm    pf_state_q;
    t_pf_fsm    pf_state_d;
    t_line      pf_next_q;
    t_line      pf_next_d;
    t_line      last_line_q;
    t_line      last_line_d;
    logic       last_vld_q;
    logic       last_vld_d;
    logic [2:0] pf_left_q;
    logic [2:0] pf_left_d;
    t_line      dmd_line_s;
    logic       arm_s;
    logic       pf_out_s;

    assign dmd_line_s = addr_line(fe_req_nnn.addr);
    assign arm_s      = fe_req_nnn.valid & (~last_vld_q | (dmd_line_s != last_line_q));
    // Two free entries required so a demand can always still allocate
    assign pf_issue_s = ~reset & (pf_state_q == PF_ISSUE) & ~fe_req_nnn.valid
                        & ~flush_s & two_free_s;
    assign pf_addr_s  = {pf_next_q, {LINE_OFF{1'b0}}};

    // Any prefetch still in flight in the table
    always_comb begin
        pf_out_s = 1'b0;
        for (int i = 0; i < NE; i++) begin
            pf_out_s = pf_out_s | (trk_q[i].valid & trk_q[i].is_pf);
        end
    end

    assign pf_busy = ~reset & ((pf_state_q != PF_IDLE) | pf_out_s);

    // Prefetch FSM next state; flush beats arm, arm restarts any run
    always_comb begin
        pf_state_d  = pf_state_q;
        pf_next_d   = pf_next_q;
        pf_left_d   = pf_left_q;
        last_line_d = last_line_q;
        last_vld_d  = last_vld_q;
        if (flush_s) begin
            pf_state_d = PF_FLUSH;
            pf_left_d  = 3'd0;
            last_vld_d = 1'b0;
        end else if (arm_s) begin
            pf_state_d  = PF_ISSUE;
            pf_next_d   = dmd_line_s + LINE_W'(1);
            pf_left_d   = 3'(PF_DEPTH);
            last_line_d = dmd_line_s;
            last_vld_d  = 1'b1;
        end else begin
            case (pf_state_q)
                PF_IDLE: begin
                    pf_state_d = PF_IDLE;
                end
                PF_ISSUE: begin
                    if (pf_issue_s) begin
                        pf_next_d  = pf_next_q + LINE_W'(1);
                        pf_left_d  = pf_left_q - 3'd1;
                        pf_state_d = (pf_left_q == 3'd1) ? PF_IDLE : PF_ISSUE;
                    end else if (!two_free_s) begin
                        pf_state_d = PF_WAIT;
                    end else begin
                        pf_state_d = PF_ISSUE;
                    end
                end
                PF_WAIT: begin
                    pf_state_d = two_free_s ? PF_ISSUE : PF_WAIT;
                end
                PF_FLUSH: begin
                    pf_state_d = PF_IDLE;
                end
                default: begin
                    pf_state_d = PF_IDLE;
                end
            endcase
        end
    end

    // Prefetch FSM and line-tracking registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pf_state_q  <= PF_IDLE;
            pf_next_q   <= '0;
            pf_left_q   <= 3'd0;
            last_line_q <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            pf_state_q  <= pf_state_d;
            pf_next_q   <= pf_next_d;
            pf_left_q   <= pf_left_d;
            last_line_q <= last_line_d;
            last_vld_q  <= last_vld_d;
        end
    end
`else
    assign pf_issue_s = 1'b0;
    assign pf_addr_s  = '0;
    assign pf_busy    = 1'b0;
`endif

    fe_fb_arb_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .rsp_valid (fb_rsp_nnn.valid),
        .rsp_hit   (hit_s.valid),
        .dmd_valid (fe_req_nnn.valid),
        .any_free  (any_free_s),
        .two_free  (two_free_s),
        .flush     (flush_s)
    );

endmodule
